// File: rtl/noc_alloc_pkg.sv
// -----------------------------------------------------------------------------
// noc_alloc_pkg
// Shared definitions for the wormhole switch allocators.
//   - st_e     : output-allocator state encoding (ST_IDLE / ST_LOCKED)
//   - IN_N_DEF : default number of input ports per switch
//   - CREDITS_DEF : default downstream buffer depth in flits
// Used by wormhole_out_alloc, the switch top and the testbench.
// -----------------------------------------------------------------------------
package noc_alloc_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } st_e;

    localparam int IN_N_DEF    = 5;
    localparam int CREDITS_DEF = 4;

endpackage : noc_alloc_pkg

// File: rtl/wormhole_out_alloc_rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority picker. Returns the first set bit of req
// found when scanning ptr, ptr+1, ... cyclically modulo N. Also used by the
// input-side VC allocator.
//
// Ports:
//   req   [N-1:0]      request vector
//   ptr   [IDX_W-1:0]  highest-priority index (must be < N)
//   idx   [IDX_W-1:0]  winning index (ptr when nothing is requested)
//   found              at least one request bit is set
// -----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter  int N     = 5,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before the loop, so no path
        // through this block leaves a signal unassigned (no latch inferred).
        idx   = ptr;
        found = 1'b0;
        j     = 0;
        // Scan from the lowest priority (offset N-1) up to ptr itself; the
        // last hit written is the one closest to ptr, i.e. the winner.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                idx   = IDX_W'(j);
                found = 1'b1;
            end
        end
    end

endmodule : rr_priority_pick

// File: rtl/wormhole_out_alloc.sv
// -----------------------------------------------------------------------------
// wormhole_out_alloc
// Per-output-port allocator of the wormhole switch. Shares the output among
// IN_N inputs with work-conserving round-robin, holds the grant from head to
// tail flit, and gates every transfer on a downstream credit counter.
//
// Optional feature: define WORMHOLE_OUT_ALLOC_STATS_EN to add the packet and
// credit-stall counters (pkt_cnt_o, stall_cnt_o).
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   req_i   [IN_N] input i presents a flit routed here
//   tail_i  [IN_N] flit presented by input i is a tail
//   credit_i       downstream freed one slot (1-cycle pulse)
//   grant_o        selected input index (crossbar mux select)
//   grant_vld_o    a flit transfers this cycle
//   ack_o   [IN_N] one-hot pop strobe to the granted input
//   credit_cnt_o   current credit count
//   credit_ovf_o   credit arrived with the counter already full
//   pkt_cnt_o      (stats) packets completed, wrapping
//   stall_cnt_o    (stats) cycles blocked on credits, saturating
// -----------------------------------------------------------------------------
module wormhole_out_alloc
    import noc_alloc_pkg::*;
#(
    parameter  int IN_N    = IN_N_DEF,
    parameter  int CREDITS = CREDITS_DEF,
    parameter  int CNT_W   = $clog2(CREDITS + 1),
    localparam int IDX_W   = (IN_N > 1) ? $clog2(IN_N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IN_N-1:0]  req_i,
    input  logic [IN_N-1:0]  tail_i,
    input  logic             credit_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             grant_vld_o,
    output logic [IN_N-1:0]  ack_o,
    output logic [CNT_W-1:0] credit_cnt_o,
    output logic             credit_ovf_o
`ifdef WORMHOLE_OUT_ALLOC_STATS_EN
    ,
    output logic [15:0]      pkt_cnt_o,
    output logic [15:0]      stall_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);

    st_e              st_q, st_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] rr_idx;
    logic             rr_found;
    logic [IDX_W-1:0] cand_idx;
    logic             cand_vld;
    logic             xfer;
    logic             cand_tail;

    rr_priority_pick #(
        .N (IN_N)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // Candidate selection: round-robin when idle, owner only while locked.
    always_comb begin
        cand_idx = ptr_q;
        cand_vld = 1'b0;
        if (st_q == ST_LOCKED) begin
            cand_vld = req_i[owner_q];
            if (req_i[owner_q]) begin
                cand_idx = owner_q;
            end
        end else begin
            cand_vld = rr_found;
            cand_idx = rr_idx;
        end
    end

    assign cand_tail = tail_i[cand_idx];
    assign xfer      = cand_vld && (cnt_q != '0) && !rst_i;

    assign grant_o      = rst_i ? '0 : cand_idx;
    assign grant_vld_o  = xfer;
    assign ack_o        = xfer ? (IN_N'(1) << cand_idx) : '0;
    assign credit_cnt_o = rst_i ? CNT_FULL : cnt_q;
    // A credit coinciding with a transfer is absorbed, so it cannot overflow.
    assign credit_ovf_o = credit_i && !xfer && (cnt_q == CNT_FULL) && !rst_i;

    // Next-state logic.
    always_comb begin
        st_d    = st_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        if (xfer && !credit_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (credit_i && !xfer && (cnt_q != CNT_FULL)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (xfer) begin
            if (st_q == ST_IDLE) begin
                ptr_d = (cand_idx == IDX_W'(IN_N - 1)) ? '0 : cand_idx + IDX_W'(1);
                if (!cand_tail) begin
                    st_d    = ST_LOCKED;
                    owner_d = cand_idx;
                end
            end else if (cand_tail) begin
                st_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous and covers every state flop; a reset
        // mid-packet simply abandons the packet.
        if (rst_i) begin
            st_q    <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= CNT_FULL;
        end else begin
            // NOTE: non-blocking assignments for all state so every flop
            // samples the pre-edge values regardless of statement order.
            st_q    <= st_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WORMHOLE_OUT_ALLOC_STATS_EN
    logic [15:0] pkt_cnt_q, stall_cnt_q;
    logic        stall;

    assign stall = cand_vld && (cnt_q == '0) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (xfer && cand_tail) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_cnt_o   = pkt_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule : wormhole_out_alloc

// File: tb/tb_wormhole_out_alloc.sv
// -----------------------------------------------------------------------------
// tb_wormhole_out_alloc
// Directed testbench for wormhole_out_alloc with IN_N=5, CREDITS=4. Inputs
// change on the falling edge; combinational outputs are checked 1 time unit
// later, well before the next rising edge.
// Define WORMHOLE_OUT_ALLOC_STATS_EN to also check the stats counters.
// -----------------------------------------------------------------------------
module tb_wormhole_out_alloc;
    import noc_alloc_pkg::*;

    localparam int IN_N    = IN_N_DEF;
    localparam int CREDITS = CREDITS_DEF;
    localparam int CNT_W   = $clog2(CREDITS + 1);
    localparam int IDX_W   = $clog2(IN_N);

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [IN_N-1:0]  req_i = '0;
    logic [IN_N-1:0]  tail_i = '0;
    logic             credit_i = 1'b0;
    logic [IDX_W-1:0] grant_o;
    logic             grant_vld_o;
    logic [IN_N-1:0]  ack_o;
    logic [CNT_W-1:0] credit_cnt_o;
    logic             credit_ovf_o;
`ifdef WORMHOLE_OUT_ALLOC_STATS_EN
    logic [15:0]      pkt_cnt_o;
    logic [15:0]      stall_cnt_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    wormhole_out_alloc #(
        .IN_N    (IN_N),
        .CREDITS (CREDITS)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .tail_i       (tail_i),
        .credit_i     (credit_i),
        .grant_o      (grant_o),
        .grant_vld_o  (grant_vld_o),
        .ack_o        (ack_o),
        .credit_cnt_o (credit_cnt_o),
        .credit_ovf_o (credit_ovf_o)
`ifdef WORMHOLE_OUT_ALLOC_STATS_EN
        ,
        .pkt_cnt_o    (pkt_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and let outputs settle.
    task automatic step(input logic rst, input logic [IN_N-1:0] req,
                        input logic [IN_N-1:0] tail, input logic cr);
        @(negedge clk_i);
        rst_i    = rst;
        req_i    = req;
        tail_i   = tail;
        credit_i = cr;
        #1;
    endtask

    // Check grant, valid and the matching one-hot ack together.
    task automatic expect_grant(input string tag, input logic vld, input int g);
        logic [IN_N-1:0] ack_exp;
        ack_exp = '0;
        if (vld) ack_exp[g] = 1'b1;
        check({tag, ".vld"},   32'(grant_vld_o), 32'(vld));
        check({tag, ".grant"}, 32'(grant_o),     32'(g));
        check({tag, ".ack"},   32'(ack_o),       32'(ack_exp));
    endtask

    initial begin
        // ---------------- reset state ----------------
        step(1'b1, 5'b11111, 5'b11111, 1'b1);
        expect_grant("rst", 1'b0, 0);
        check("rst.cnt", 32'(credit_cnt_o), 32'd4);
        check("rst.ovf", 32'(credit_ovf_o), 32'd0);
        step(1'b1, 5'b00000, 5'b00000, 1'b0);
        check("rst2.cnt", 32'(credit_cnt_o), 32'd4);

        // ---------------- single-flit fairness ----------------
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 5'b11111, 5'b11111, 1'b1);
            expect_grant($sformatf("fair%0d", k), 1'b1, k % 5);
            check($sformatf("fair%0d.cnt", k), 32'(credit_cnt_o), 32'd4);
        end

        // ---------------- work-conserving skip (ptr=0) ----------------
        step(1'b0, 5'b10100, 5'b11111, 1'b1); expect_grant("skip0", 1'b1, 2);
        step(1'b0, 5'b10100, 5'b11111, 1'b1); expect_grant("skip1", 1'b1, 4);
        step(1'b0, 5'b10100, 5'b11111, 1'b1); expect_grant("skip2", 1'b1, 2);
        step(1'b0, 5'b10100, 5'b11111, 1'b1); expect_grant("skip3", 1'b1, 4);

        // ---------------- wormhole lock (ptr=0) ----------------
        step(1'b0, 5'b01010, 5'b00000, 1'b1); expect_grant("lock.head", 1'b1, 1);
        step(1'b0, 5'b01010, 5'b00000, 1'b1); expect_grant("lock.body", 1'b1, 1);
        // Bubble: input 3 still requesting but ignored; grant_o shows ptr=2.
        step(1'b0, 5'b01000, 5'b00000, 1'b0); expect_grant("lock.bubble", 1'b0, 2);
        step(1'b0, 5'b01010, 5'b00010, 1'b1); expect_grant("lock.tail", 1'b1, 1);
        step(1'b0, 5'b01000, 5'b01000, 1'b1); expect_grant("lock.next", 1'b1, 3);
        check("lock.cnt", 32'(credit_cnt_o), 32'd4);

        // ---------------- credit exhaustion (ptr=4) ----------------
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 5'b00001, 5'b00000, 1'b0);
            expect_grant($sformatf("exh%0d", k), 1'b1, 0);
            check($sformatf("exh%0d.cnt", k), 32'(credit_cnt_o), 32'(4 - k));
        end
        step(1'b0, 5'b00001, 5'b00000, 1'b0);
        expect_grant("exh4", 1'b0, 0);
        check("exh4.cnt", 32'(credit_cnt_o), 32'd0);
        step(1'b0, 5'b00001, 5'b00000, 1'b0);
        expect_grant("exh5", 1'b0, 0);
        // Credit arrives: no transfer yet this cycle, exactly one next cycle.
        step(1'b0, 5'b00001, 5'b00000, 1'b1); expect_grant("exh.cr", 1'b0, 0);
        step(1'b0, 5'b00001, 5'b00000, 1'b0); expect_grant("exh.one", 1'b1, 0);
        check("exh.one.cnt", 32'(credit_cnt_o), 32'd1);
        step(1'b0, 5'b00001, 5'b00000, 1'b0); expect_grant("exh.none", 1'b0, 0);
        check("exh.none.cnt", 32'(credit_cnt_o), 32'd0);
        // Refill one, then simultaneous credit + transfer keeps cnt at 1.
        step(1'b0, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b00001, 5'b00000, 1'b1); expect_grant("sim0", 1'b1, 0);
        check("sim0.cnt", 32'(credit_cnt_o), 32'd1);
        step(1'b0, 5'b00001, 5'b00001, 1'b1); expect_grant("sim1", 1'b1, 0);
        check("sim1.cnt", 32'(credit_cnt_o), 32'd1);
        // Refill to full (ptr now 1, IDLE).
        step(1'b0, 5'b00000, 5'b00000, 1'b1);
        check("refill1.cnt", 32'(credit_cnt_o), 32'd1);
        step(1'b0, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b00000, 5'b00000, 1'b1);

        // ---------------- overflow ----------------
        step(1'b0, 5'b00000, 5'b00000, 1'b1);
        check("ovf.pulse", 32'(credit_ovf_o), 32'd1);
        check("ovf.cnt", 32'(credit_cnt_o), 32'd4);
        expect_grant("ovf.idle", 1'b0, 1);
        step(1'b0, 5'b00000, 5'b00000, 1'b0);
        check("ovf.clear", 32'(credit_ovf_o), 32'd0);
        check("ovf.hold", 32'(credit_cnt_o), 32'd4);

        // ---------------- reset mid-packet ----------------
        step(1'b0, 5'b00100, 5'b00000, 1'b1); expect_grant("mid.head", 1'b1, 2);
        step(1'b0, 5'b00101, 5'b00000, 1'b1); expect_grant("mid.body", 1'b1, 2);
        step(1'b1, 5'b00101, 5'b00000, 1'b1); expect_grant("mid.rst", 1'b0, 0);
        check("mid.rst.ovf", 32'(credit_ovf_o), 32'd0);
        step(1'b0, 5'b00101, 5'b00101, 1'b1); expect_grant("post.first", 1'b1, 0);
        check("post.cnt", 32'(credit_cnt_o), 32'd4);
        step(1'b0, 5'b00100, 5'b00100, 1'b1); expect_grant("post.second", 1'b1, 2);

        // ---------------- stats: 3 packets + 7 stalled cycles ----------------
        step(1'b1, 5'b00000, 5'b00000, 1'b0);
        step(1'b0, 5'b00010, 5'b00000, 1'b0); expect_grant("st.pA.h", 1'b1, 1);
        step(1'b0, 5'b00010, 5'b00010, 1'b0); expect_grant("st.pA.t", 1'b1, 1);
        step(1'b0, 5'b01000, 5'b01000, 1'b0); expect_grant("st.pB", 1'b1, 3);
        step(1'b0, 5'b00001, 5'b00001, 1'b0); expect_grant("st.pC", 1'b1, 0);
        check("st.empty", 32'(credit_cnt_o), 32'd1);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 5'b00100, 5'b00100, 1'b0);
        end
        expect_grant("st.blocked", 1'b0, 2);
        step(1'b0, 5'b00000, 5'b00000, 1'b0);
`ifdef WORMHOLE_OUT_ALLOC_STATS_EN
        check("stats.pkt",   32'(pkt_cnt_o),   32'd3);
        check("stats.stall", 32'(stall_cnt_o), 32'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_wormhole_out_alloc
